// File: rtl/divisor_secuencial.sv
// -----------------------------------------------------------------------------
// divisor_secuencial
//   Sequential unsigned restoring divider. One quotient bit is resolved per
//   clock: the block presents {R,Qmsb} and D to an external restador, then
//   keeps the difference (carry out = 1) or the shifted remainder (carry
//   out = 0). A result is ready after WIDTH iteration cycles.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   inicio            start request, only honoured in IDLE
//   dividendo/divisor operands, captured when inicio is accepted
//   res_minuendo      to restador: {R[WIDTH-2:0], Q[WIDTH-1]}
//   res_sustraendo    to restador: D
//   res_resta         from restador: (minuendo - sustraendo) mod 2^WIDTH
//   res_cout          from restador: 1 when minuendo >= sustraendo
//   cociente/residuo  registered quotient / remainder
//   ocupado           high while in CALC or FIN
//   listo             one-cycle done pulse (asserted during FIN)
//   div_cero          divide-by-zero flag, held until the next accepted start
// -----------------------------------------------------------------------------
module divisor_secuencial #(
    parameter int WIDTH = 5,
    parameter int CW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inicio,
    input  logic [WIDTH-1:0] dividendo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] res_minuendo,
    output logic [WIDTH-1:0] res_sustraendo,
    input  logic [WIDTH-1:0] res_resta,
    input  logic             res_cout,
    output logic [WIDTH-1:0] cociente,
    output logic [WIDTH-1:0] residuo,
    output logic             ocupado,
    output logic             listo,
    output logic             div_cero
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    localparam logic [CW-1:0] ULTIMA = CW'(WIDTH - 1);

    logic [1:0]       estado;
    logic [WIDTH-1:0] r;      // partial remainder
    logic [WIDTH-1:0] q;      // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] d;      // latched divisor
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] r_sig;
    logic [WIDTH-1:0] q_sig;

    // The shifted remainder always fits in WIDTH bits: before iteration k the
    // remainder is below 2^(k-1), so no extra carry bit is carried along.
    assign res_minuendo   = {r[WIDTH-2:0], q[WIDTH-1]};
    assign res_sustraendo = d;

    always_comb begin
        r_sig = res_minuendo;
        q_sig = {q[WIDTH-2:0], 1'b0};
        if (res_cout) begin
            r_sig = res_resta;
            q_sig = {q[WIDTH-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado   <= S_IDLE;
            r        <= '0;
            q        <= '0;
            d        <= '0;
            cnt      <= '0;
            cociente <= '0;
            residuo  <= '0;
            ocupado  <= 1'b0;
            listo    <= 1'b0;
            div_cero <= 1'b0;
        end else begin
            listo <= 1'b0;
            case (estado)
                S_IDLE: begin
                    if (inicio) begin
                        ocupado <= 1'b1;
                        if (divisor == '0) begin
                            // Nothing to iterate: publish the result directly.
                            cociente <= '1;
                            residuo  <= dividendo;
                            div_cero <= 1'b1;
                            listo    <= 1'b1;
                            estado   <= S_FIN;
                        end else begin
                            q        <= dividendo;
                            d        <= divisor;
                            r        <= '0;
                            cnt      <= '0;
                            div_cero <= 1'b0;
                            estado   <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    r   <= r_sig;
                    q   <= q_sig;
                    cnt <= cnt + CW'(1);
                    if (cnt == ULTIMA) begin
                        cociente <= q_sig;
                        residuo  <= r_sig;
                        listo    <= 1'b1;
                        estado   <= S_FIN;
                    end
                end
                S_FIN: begin
                    ocupado <= 1'b0;
                    estado  <= S_IDLE;
                end
                default: begin
                    ocupado <= 1'b0;
                    estado  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divisor_secuencial.sv
// -----------------------------------------------------------------------------
// tb_divisor_secuencial
//   Directed + randomized bench for divisor_secuencial (WIDTH=5). The restador
//   is modelled behaviourally; expected results come from plain / and %.
// -----------------------------------------------------------------------------
module tb_divisor_secuencial;

    localparam int W  = 5;
    localparam int CW = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         inicio;
    logic [W-1:0] dividendo, divisor;
    logic [W-1:0] res_minuendo, res_sustraendo, res_resta;
    logic         res_cout;
    logic [W-1:0] cociente, residuo;
    logic         ocupado, listo, div_cero;

    int checks = 0;
    int passed = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // behavioural restador
    assign res_resta = res_minuendo - res_sustraendo;
    assign res_cout  = (res_minuendo >= res_sustraendo);

    divisor_secuencial #(.WIDTH(W), .CW(CW)) dut (
        .clk(clk), .rst(rst), .inicio(inicio),
        .dividendo(dividendo), .divisor(divisor),
        .res_minuendo(res_minuendo), .res_sustraendo(res_sustraendo),
        .res_resta(res_resta), .res_cout(res_cout),
        .cociente(cociente), .residuo(residuo),
        .ocupado(ocupado), .listo(listo), .div_cero(div_cero)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Drive a one-cycle start from a negedge; returns at the negedge of the
    // first cycle after the accepting edge.
    task automatic pulse_start(input logic [W-1:0] n, input logic [W-1:0] dv);
        inicio    = 1'b1;
        dividendo = n;
        divisor   = dv;
        @(negedge clk);
        inicio    = 1'b0;
    endtask

    // lat = cycle index (1 = first cycle after acceptance) where listo is seen
    task automatic wait_listo(output int lat);
        lat = 1;
        while (listo !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic divide(input logic [W-1:0] n, input logic [W-1:0] dv,
                          input string tag, input bit full);
        int           lat;
        logic [W-1:0] eq, er;
        int           elat;
        eq   = (dv == 0) ? {W{1'b1}} : W'(int'(n) / int'(dv));
        er   = (dv == 0) ? n : W'(int'(n) % int'(dv));
        elat = (dv == 0) ? 1 : W + 1;
        pulse_start(n, dv);
        if (full) chk({tag, " ocupado"}, 32'(ocupado), 32'd1);
        wait_listo(lat);
        if (full) begin
            chk({tag, " latency"},  32'(lat),      32'(elat));
            chk({tag, " cociente"}, 32'(cociente), 32'(eq));
            chk({tag, " residuo"},  32'(residuo),  32'(er));
            chk({tag, " div_cero"}, 32'(div_cero), 32'(dv == 0));
            @(negedge clk);
            chk({tag, " listo one cycle"}, 32'(listo), 32'd0);
        end else begin
            chk(tag, {8'(lat), 8'(cociente), 8'(residuo), 8'(div_cero)},
                     {8'(elat), 8'(eq), 8'(er), 8'(dv == 0)});
            @(negedge clk);
        end
    endtask

    initial begin
        int           pulses, lat, t1, t2;
        logic [W-1:0] qc, rc;

        rst = 1'b1; inicio = 1'b0; dividendo = '0; divisor = '0;
        repeat (3) @(negedge clk);
        chk("reset outputs", {27'(cociente), residuo}, 32'd0);
        chk("reset flags", {29'd0, ocupado, listo, div_cero}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        divide(5'd23, 5'd4,  "23/4",  1'b1);
        divide(5'd31, 5'd1,  "31/1",  1'b1);
        divide(5'd3,  5'd5,  "3/5",   1'b1);
        divide(5'd31, 5'd31, "31/31", 1'b1);
        divide(5'd7,  5'd0,  "7/0",   1'b1);
        chk("div_cero held in idle", 32'(div_cero), 32'd1);
        divide(5'd10, 5'd3,  "10/3 after div0", 1'b1);

        // start re-pulsed during CALC must be ignored
        pulse_start(5'd23, 5'd4);
        pulse_start(5'd9, 5'd2);
        pulses = 0; qc = '0; rc = '0;
        repeat (12) begin
            if (listo === 1'b1) begin
                pulses++;
                qc = cociente;
                rc = residuo;
            end
            @(negedge clk);
        end
        chk("ignore pulses", 32'(pulses), 32'd1);
        chk("ignore result", {qc, rc}, {5'd5, 5'd3});

        // reset in the third CALC cycle
        pulse_start(5'd23, 5'd4);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midreset outputs", {cociente, residuo, ocupado, listo, div_cero}, 13'd0);
        rst = 1'b0;
        pulses = 0;
        repeat (10) begin
            if (listo === 1'b1) pulses++;
            @(negedge clk);
        end
        chk("midreset no listo", 32'(pulses), 32'd0);
        divide(5'd17, 5'd3, "17/3 after reset", 1'b1);

        // back-to-back with inicio in the IDLE cycle right after FIN
        pulse_start(5'd20, 5'd3);
        wait_listo(lat);
        t1 = cyc;
        chk("b2b first", {cociente, residuo}, {5'd6, 5'd2});
        @(negedge clk);
        pulse_start(5'd15, 5'd4);
        wait_listo(lat);
        t2 = cyc;
        chk("b2b second", {cociente, residuo}, {5'd3, 5'd3});
        chk("b2b spacing", 32'(t2 - t1), 32'd7);
        @(negedge clk);

        // random operands, divisor zero included
        repeat (40) begin
            divide(W'($urandom_range(0, 31)), W'($urandom_range(0, 31)), "random", 1'b0);
        end

        // exhaustive nonzero-divisor sweep
        for (int n = 0; n < 32; n++) begin
            for (int dv = 1; dv < 32; dv++) begin
                divide(W'(n), W'(dv), "sweep", 1'b0);
            end
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/divisor_secuencial.md
Name: divisor_secuencial

Overview:
- Sequential unsigned restoring divider, WIDTH-bit dividend and divisor.
- Sits directly around the restador stage: each cycle it drives minuendo/sustraendo into the external restador, then consumes the restador's difference and carry-out.
- Produces a registered quotient and remainder after WIDTH iteration cycles, with a start/done handshake.

Parameters:
- WIDTH, 5, operand/result width; must equal the restador width.
- CW, 3, iteration counter width; must satisfy 2^CW > WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- inicio  input  1  start request; sampled only in IDLE.
- dividendo  input  WIDTH  dividend, captured when inicio accepted.
- divisor  input  WIDTH  divisor, captured when inicio accepted.
- res_minuendo  output  WIDTH  to restador minuendo.
- res_sustraendo  output  WIDTH  to restador sustraendo.
- res_resta  input  WIDTH  from restador: (minuendo − sustraendo) mod 2^WIDTH.
- res_cout  input  1  from restador: 1 iff minuendo ≥ sustraendo.
- cociente  output  WIDTH  registered quotient.
- residuo  output  WIDTH  registered remainder.
- ocupado  output  1  high in CALC and FIN.
- listo  output  1  one-cycle done pulse.
- div_cero  output  1  divide-by-zero flag; valid with listo, held until next accepted inicio.

Behaviour:
- Reset, applied at any time including mid-operation, returns the block to IDLE on the next edge.
  - Reset values: cociente=0, residuo=0, ocupado=0, listo=0, div_cero=0.
  - Internal registers R (partial remainder), Q (dividend/quotient shift register), D (divisor) and cnt are all cleared to 0.
- States: IDLE, CALC, FIN.
- IDLE:
  - inicio=1 with divisor≠0: load Q=dividendo, D=divisor, R=0, cnt=0, clear div_cero; go to CALC.
  - inicio=1 with divisor=0: cociente=all ones, residuo=dividendo, div_cero=1; go to FIN (CALC skipped).
- CALC (one iteration per cycle, WIDTH cycles):
  - res_minuendo = {R[WIDTH-2:0], Q[WIDTH-1]}, combinational from registers.
  - res_sustraendo = D.
  - At the edge:
    - res_cout=1: R←res_resta and Q←{Q[WIDTH-2:0],1}.
    - res_cout=0: R←res_minuendo and Q←{Q[WIDTH-2:0],0}.
    - cnt←cnt+1.
  - When cnt=WIDTH−1 at the edge: cociente←final Q, residuo←final R; go to FIN.
- Width rule: before iteration k the partial remainder is below 2^(k−1), so the shifted value always fits in WIDTH bits. No extra carry bit is needed.
- FIN: listo=1 for exactly one cycle; next state IDLE.
- ocupado is registered: 1 in CALC and FIN, 0 in IDLE.
- Latency:
  - Normal division: listo high in the (WIDTH+1)th cycle after the edge that sampled inicio (6 cycles for WIDTH=5).
  - Divide-by-zero: listo high in the 1st cycle after that edge.
- inicio asserted while in CALC or FIN is ignored; it is not queued.
- Outputs hold their last result until the next accepted inicio completes.
- In IDLE and FIN, res_minuendo and res_sustraendo reflect the register contents; their values are don't-care for the restador.
- Back-to-back: inicio high in the IDLE cycle right after FIN is accepted. Minimum spacing between starts is WIDTH+2 cycles.
- Arithmetic is unsigned only; no signed mode.

Test Plan:
- Bench drives res_resta/res_cout from a behavioral restador model (difference mod 2^WIDTH, cout = minuendo ≥ sustraendo).
- dividendo=23, divisor=4, inicio 1 cycle -> ocupado high; listo pulses 6 cycles later with cociente=5, residuo=3, div_cero=0.
- 31/1 -> cociente=31, residuo=0; 3/5 -> cociente=0, residuo=3; 31/31 -> cociente=1, residuo=0; exhaustive sweep of all 32×31 nonzero-divisor pairs matches q=N/D, r=N%D.
- dividendo=7, divisor=0 -> listo 1 cycle after acceptance, div_cero=1, cociente=31, residuo=7; the next valid division clears div_cero.
- Start 23/4, re-pulse inicio with 9/2 during CALC -> ignored; result 5/3; exactly one listo pulse.
- Start 23/4, assert rst in the 3rd CALC cycle -> next cycle state IDLE, all outputs 0, no listo; a fresh 17/3 then yields cociente=5, residuo=2.
- Back-to-back 20/3 then 15/4 with inicio in the cycle after FIN -> results 6/2 then 3/3, listo pulses 7 cycles apart.
